// File: rtl/tx_packet_framer_if.sv
// Request/response and tx FIFO write signals for the packet framer.
// Latency: none, plain wires grouped for port connection.
// Backpressure: tx_fifo_wfull from the FIFO side stalls the framer.
interface tx_packet_framer_if #(
  parameter int DATA_BYTES = 4
);
  logic                      send;
  logic [7:0]                pkt_type;
  logic [2:0]                pkt_len;
  logic [8*DATA_BYTES-1:0]   pkt_data;
  logic                      busy;
  logic                      done;
  logic [7:0]                tx_fifo_wdata;
  logic                      tx_fifo_winc;
  logic                      tx_fifo_wfull;

  // Controller plus FIFO environment side
  modport master (
    output send, pkt_type, pkt_len, pkt_data, tx_fifo_wfull,
    input  busy, done, tx_fifo_wdata, tx_fifo_winc
  );

  // Framer side
  modport slave (
    input  send, pkt_type, pkt_len, pkt_data, tx_fifo_wfull,
    output busy, done, tx_fifo_wdata, tx_fifo_winc
  );
endinterface

// File: rtl/tx_packet_framer.sv
// Serialises one response word into sync/type/len/payload/xor-checksum bytes for the tx FIFO.
// Latency: first byte one cycle after send, 4+L bytes back to back, done one cycle after the last.
// Backpressure: tx_fifo_wfull holds state and byte; nothing is dropped or repeated.
module tx_packet_framer #(
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  tx_packet_framer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    TYPE = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    CSUM = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [2:0] MAX_LEN = 3'(DATA_BYTES);

  state_t                  state;
  logic [7:0]              type_q;
  logic [2:0]              len_q;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [2:0]              idx;
  logic [7:0]              csum_q;
  logic [7:0]              wdata_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    emit;
  logic                    consume;
  logic [7:0]              csum_nxt;
  logic [2:0]              eff_len;

  // Select payload byte i; the loop keeps the index inside the payload width
  function automatic logic [7:0] byte_at(input logic [8*DATA_BYTES-1:0] d, input logic [2:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (i == 3'(k)) b = d[8*k +: 8];
    end
    return b;
  endfunction

  assign eff_len  = (bus.pkt_len > MAX_LEN) ? MAX_LEN : bus.pkt_len;
  assign emit     = (state == SYNC) || (state == TYPE) || (state == LEN) ||
                    (state == DATA) || (state == CSUM);
  // A byte is consumed exactly when the strobe is high
  assign consume  = emit && !bus.tx_fifo_wfull;
  // Checksum including the byte currently presented (never used in SYNC)
  assign csum_nxt = csum_q ^ wdata_q;

  assign bus.tx_fifo_winc  = consume;
  assign bus.tx_fifo_wdata = wdata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

  // Frame sequencer: wdata_q always holds the byte for the current emit state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      type_q  <= 8'h00;
      len_q   <= 3'd0;
      data_q  <= '0;
      idx     <= 3'd0;
      csum_q  <= 8'h00;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.send) begin
            type_q  <= bus.pkt_type;
            len_q   <= eff_len;
            data_q  <= bus.pkt_data;
            idx     <= 3'd0;
            csum_q  <= 8'h00;
            wdata_q <= SYNC_BYTE;
            busy_q  <= 1'b1;
            state   <= SYNC;
          end
        end
        SYNC: begin
          if (consume) begin
            wdata_q <= type_q;
            state   <= TYPE;
          end
        end
        TYPE: begin
          if (consume) begin
            csum_q  <= csum_nxt;
            wdata_q <= {5'd0, len_q};
            state   <= LEN;
          end
        end
        LEN: begin
          if (consume) begin
            csum_q <= csum_nxt;
            if (len_q == 3'd0) begin
              wdata_q <= csum_nxt;
              state   <= CSUM;
            end else begin
              wdata_q <= byte_at(data_q, 3'd0);
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (consume) begin
            csum_q <= csum_nxt;
            if (idx == len_q - 3'd1) begin
              idx     <= 3'd0;
              wdata_q <= csum_nxt;
              state   <= CSUM;
            end else begin
              idx     <= idx + 3'd1;
              wdata_q <= byte_at(data_q, idx + 3'd1);
            end
          end
        end
        CSUM: begin
          if (consume) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_framer.sv
// Scoreboard bench for tx_packet_framer: expected bytes queued at send, popped per FIFO write.
// Latency: checks first write, last write and done cycle relative to the send cycle.
// Backpressure: drives wfull stalls and checks winc stays low while full.
module tb_tx_packet_framer;

  localparam int DB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  tx_packet_framer_if #(.DATA_BYTES(DB)) bus ();

  tx_packet_framer #(.DATA_BYTES(DB), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         winc_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         first_winc_cyc = 0;
  int         last_winc_cyc  = 0;
  bit         first_armed    = 1'b0;
  int         send_cyc       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every FIFO write pops one expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_fifo_wfull) check("winc_while_full", 32'(bus.tx_fifo_winc), 32'd0);
      if (bus.tx_fifo_winc) begin
        winc_cnt++;
        last_winc_cyc = cyc;
        if (first_armed) begin
          first_winc_cyc = cyc;
          first_armed    = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, bus.tx_fifo_wdata}, 32'h100);
        end else begin
          check("byte", {24'h0, bus.tx_fifo_wdata}, {24'h0, exp_q.pop_front()});
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Reference frame builder
  function automatic int eff_len(input logic [2:0] len);
    return (int'(len) > DB) ? DB : int'(len);
  endfunction

  task automatic push_frame(input logic [7:0] t, input logic [2:0] len, input logic [31:0] d);
    int         l;
    logic [7:0] c;
    logic [7:0] b;
    l = eff_len(len);
    exp_q.push_back(8'hA5);
    exp_q.push_back(t);
    exp_q.push_back(8'(l));
    c = t ^ 8'(l);
    for (int i = 0; i < l; i++) begin
      b = d[8*i +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  // One-cycle send pulse; returns #1 after the accepting edge
  task automatic do_send(input logic [7:0] t, input logic [2:0] len, input logic [31:0] d,
                         input bit expect_frame);
    @(posedge clk); #1;
    bus.send     = 1'b1;
    bus.pkt_type = t;
    bus.pkt_len  = len;
    bus.pkt_data = d;
    if (expect_frame) begin
      send_cyc    = cyc;
      first_armed = 1'b1;
      push_frame(t, len, d);
    end
    @(posedge clk); #1;
    bus.send = 1'b0;
  endtask

  // Wait for done, then check frame timing and cleanup
  task automatic finish_frame(input string tag, input int l, input int stall,
                              input int done0, input int winc0);
    int n;
    n = 0;
    while (done_cnt == done0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt - done0), 32'd1);
    check({tag, "_first_winc"}, 32'(first_winc_cyc - send_cyc), 32'd1);
    check({tag, "_last_winc"}, 32'(last_winc_cyc - send_cyc), 32'(4 + l + stall));
    check({tag, "_done_cyc"}, 32'(done_cyc - send_cyc), 32'(5 + l + stall));
    check({tag, "_nbytes"}, 32'(winc_cnt - winc0), 32'(4 + l));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt - done0), 32'd1);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int w0;
    bus.send          = 1'b0;
    bus.pkt_type      = 8'h00;
    bus.pkt_len       = 3'd0;
    bus.pkt_data      = '0;
    bus.tx_fifo_wfull = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_winc", 32'(bus.tx_fifo_winc), 32'd0);
    check("rst_wdata", {24'h0, bus.tx_fifo_wdata}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame: A5 01 04 FF 03 00 00 F9
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h01, 3'd4, 32'h0000_03FF, 1'b1);
    check("basic_busy", 32'(bus.busy), 32'd1);
    finish_frame("basic", 4, 0, d0, w0);

    // Backpressure: wfull high for 3 cycles while TYPE is presented
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h01, 3'd4, 32'h0000_03FF, 1'b1);
    @(posedge clk); #1;
    bus.tx_fifo_wfull = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.tx_fifo_wfull = 1'b0;
    finish_frame("bp", 4, 3, d0, w0);

    // Header-only frame: A5 10 00 10
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h10, 3'd0, 32'hDEAD_BEEF, 1'b1);
    finish_frame("hdr", 0, 0, d0, w0);

    // Clamp: len 7 -> 4, A5 02 04 11 22 33 44 42
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h02, 3'd7, 32'h4433_2211, 1'b1);
    finish_frame("clamp", 4, 0, d0, w0);

    // Request while busy: EE send during DATA is ignored
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h01, 3'd4, 32'h0000_03FF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    do_send(8'hEE, 3'd2, 32'h0000_EEEE, 1'b0);
    finish_frame("ignore", 4, 0, d0, w0);

    // Reset mid-frame, right after the LEN byte is written
    do_send(8'h33, 3'd3, 32'h00CC_BBAA, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("winc_before_reset", 32'(bus.tx_fifo_winc), 32'd1);
    rst_n = 1'b0;
    #1;
    check("winc_async_reset", 32'(bus.tx_fifo_winc), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_done", 32'(bus.done), 32'd0);
    w0 = winc_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_writes", 32'(winc_cnt - w0), 32'd0);
    d0 = done_cnt; w0 = winc_cnt;
    do_send(8'h5A, 3'd3, 32'h00CC_BBAA, 1'b1);
    finish_frame("after_rst", 3, 0, d0, w0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
